// File: rtl/mips_cpu_div_pkg.sv
// Shared types and constants for the DIV/DIVU sequencer and its unsigned divider.
package mips_cpu_div_pkg;

    localparam int          DIV_W   = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {IDLE, START, WAIT, FIX} div_state_t;

    // Magnitude of an operand: negated only when the op is signed and the value is negative.
    function automatic logic [DIV_W-1:0] div_mag(input logic sgn, input logic [DIV_W-1:0] x);
        return (sgn && ((x & INT_MIN) != '0)) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/mips_cpu_divideru.sv
// Unsigned restoring divider: one quotient bit per cycle, 32 cycles after start.
module mips_cpu_divideru
    import mips_cpu_div_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             done,
    output logic             dbz
);

    logic [5:0]       cnt;
    logic [DIV_W-1:0] quo, rem, dvs;
    logic [DIV_W:0]   shifted, diff;
    logic             fits;

    // Partial remainder is always below the divisor, so the shifted value fits in 33 bits
    // and bit 32 of the difference is a clean borrow flag.
    always_comb begin
        shifted = {rem, quo[DIV_W-1]};
        diff    = shifted - {1'b0, dvs};
        fits    = !diff[DIV_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            quo  <= '0;
            rem  <= '0;
            dvs  <= '0;
            done <= 1'b0;
            dbz  <= 1'b0;
        end else if (start) begin
            dvs <= divisor;
            dbz <= (divisor == '0);
            rem <= '0;
            if (dividend == '0) begin
                quo  <= '0;
                cnt  <= '0;
                done <= 1'b1;
            end else begin
                quo  <= dividend;
                cnt  <= 6'd32;
                done <= 1'b0;
            end
        end else if (cnt != '0) begin
            quo <= {quo[DIV_W-2:0], fits};
            rem <= fits ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) done <= 1'b1;
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/mips_cpu_div_ctrl.sv
// DIV/DIVU sequencer and HI/LO owner: sign handling around the unsigned divider plus MTHI/MTLO.
module mips_cpu_div_ctrl
    import mips_cpu_div_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             op_signed,
    input  logic [DIV_W-1:0] op_dividend,
    input  logic [DIV_W-1:0] op_divisor,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [DIV_W-1:0] mt_data,
    output logic [DIV_W-1:0] hi,
    output logic [DIV_W-1:0] lo,
    output logic             busy,
    output logic             dbz
);

    div_state_t       state;
    logic             sgn, dd_sign, dv_sign;
    logic [DIV_W-1:0] dd_mag, dv_mag, q_cap, r_cap;
    logic             div_start, div_done, div_dbz_unused;
    logic [DIV_W-1:0] div_q, div_r;
    logic             q_neg, r_neg;

    assign busy      = (state != IDLE);
    assign op_ready  = (state == IDLE) && !mthi && !mtlo;
    assign div_start = (state == START);
    assign q_neg     = sgn && (dd_sign ^ dv_sign);
    assign r_neg     = sgn && dd_sign;

    mips_cpu_divideru u_div (
        .clk       (clk),
        .reset     (!reset_n),
        .start     (div_start),
        .dividend  (dd_mag),
        .divisor   (dv_mag),
        .quotient  (div_q),
        .remainder (div_r),
        .done      (div_done),
        .dbz       (div_dbz_unused)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sgn     <= 1'b0;
            dd_sign <= 1'b0;
            dv_sign <= 1'b0;
            dd_mag  <= '0;
            dv_mag  <= '0;
            q_cap   <= '0;
            r_cap   <= '0;
            hi      <= '0;
            lo      <= '0;
            dbz     <= 1'b0;
        end else begin
            dbz <= 1'b0;
            // An MT write wins over everything and discards any in-flight divide.
            if (mthi || mtlo) begin
                if (mthi) hi <= mt_data;
                if (mtlo) lo <= mt_data;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (op_valid) begin
                        if (op_divisor == '0) begin
                            dbz <= 1'b1;
                        end else begin
                            sgn     <= op_signed;
                            dd_sign <= op_dividend[DIV_W-1];
                            dv_sign <= op_divisor[DIV_W-1];
                            dd_mag  <= div_mag(op_signed, op_dividend);
                            dv_mag  <= div_mag(op_signed, op_divisor);
                            state   <= START;
                        end
                    end
                    START: state <= WAIT;
                    WAIT: if (div_done) begin
                        q_cap <= div_q;
                        r_cap <= div_r;
                        state <= FIX;
                    end
                    FIX: begin
                        lo    <= q_neg ? (~q_cap + 1'b1) : q_cap;
                        hi    <= r_neg ? (~r_cap + 1'b1) : r_cap;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_div_ctrl.sv
// Directed and randomized checks of the divide sequencer against a plain-arithmetic model.
module tb_mips_cpu_div_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        op_valid = 1'b0, op_signed = 1'b0;
    logic [31:0] op_dividend = '0, op_divisor = '0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] mt_data = '0;
    logic        op_ready, busy, dbz;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    mips_cpu_div_ctrl dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_signed(op_signed), .op_dividend(op_dividend), .op_divisor(op_divisor),
        .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
        .hi(hi), .lo(lo), .busy(busy), .dbz(dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide and follow it to completion; the expected result comes from 64-bit arithmetic.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        int n;
        int exp_cycles;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        op_valid = 1'b1; op_signed = sgn; op_dividend = a; op_divisor = b;
        #1;
        check("op_ready_at_accept", {31'b0, op_ready}, 32'd1);
        step();
        op_valid = 1'b0;
        if (b == 0) begin
            check("dbz_pulse", {31'b0, dbz}, 32'd1);
            check("dbz_busy_low", {31'b0, busy}, 32'd0);
            check("dbz_ready_high", {31'b0, op_ready}, 32'd1);
            step();
            check("dbz_cleared", {31'b0, dbz}, 32'd0);
            check("dbz_hi_kept", hi, m_hi);
            check("dbz_lo_kept", lo, m_lo);
        end else begin
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
            exp_cycles = (a == 0) ? 3 : 35;
            n = 0;
            while (busy && n < 100) begin
                step();
                n++;
            end
            check("busy_cycles", n, exp_cycles);
            check("div_lo", lo, m_lo);
            check("div_hi", hi, m_hi);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic rs;
        #2;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_dbz", {31'b0, dbz}, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // Simultaneous MTHI+MTLO in idle
        mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h1234_5678;
        step();
        mthi = 1'b0; mtlo = 1'b0;
        m_hi = 32'h1234_5678; m_lo = 32'h1234_5678;
        check("mt_both_hi", hi, m_hi);
        check("mt_both_lo", lo, m_lo);
        check("mt_busy", {31'b0, busy}, 32'd0);

        do_div(1'b0, 32'd100, 32'd7);
        check("divu_100_7_lo", lo, 32'd14);
        check("divu_100_7_hi", hi, 32'd2);
        do_div(1'b1, -32'sd7, 32'd2);
        check("div_m7_2_lo", lo, 32'hFFFF_FFFD);
        do_div(1'b1, 32'd7, -32'sd2);
        check("div_7_m2_hi", hi, 32'd1);
        do_div(1'b1, -32'sd7, -32'sd2);
        check("div_m7_m2_lo", lo, 32'd3);

        mthi = 1'b1; mt_data = 32'd5; step();
        mthi = 1'b0; mtlo = 1'b1; mt_data = 32'd6; step();
        mtlo = 1'b0; m_hi = 32'd5; m_lo = 32'd6;
        do_div(1'b0, 32'd9, 32'd0);
        do_div(1'b0, 32'd0, 32'd3);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        // Abort an in-flight divide with MTHI
        op_valid = 1'b1; op_signed = 1'b0; op_dividend = 32'd1000; op_divisor = 32'd3;
        step();
        op_valid = 1'b0;
        repeat (9) step();
        mthi = 1'b1; mt_data = 32'h0000_ABCD;
        step();
        mthi = 1'b0;
        m_hi = 32'h0000_ABCD;
        check("abort_hi", hi, m_hi);
        check("abort_lo", lo, m_lo);
        check("abort_busy", {31'b0, busy}, 32'd0);
        do_div(1'b0, 32'd50, 32'd5);

        // MTLO beats a same-cycle request; the request is taken a cycle later
        mtlo = 1'b1; mt_data = 32'hCAFE_0001;
        op_valid = 1'b1; op_signed = 1'b0; op_dividend = 32'd40; op_divisor = 32'd6;
        #1;
        check("mt_blocks_ready", {31'b0, op_ready}, 32'd0);
        step();
        mtlo = 1'b0; op_valid = 1'b0;
        m_lo = 32'hCAFE_0001;
        check("mt_vs_op_lo", lo, m_lo);
        check("mt_vs_op_busy", {31'b0, busy}, 32'd0);
        do_div(1'b0, 32'd40, 32'd6);

        // Asynchronous reset in the middle of a divide
        op_valid = 1'b1; op_signed = 1'b1; op_dividend = 32'd777; op_divisor = 32'd5;
        step();
        op_valid = 1'b0;
        repeat (6) step();
        reset_n = 1'b0;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        step();
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0;
        do_div(1'b0, 32'd20, 32'd6);

        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 5))
                0: rb = rb & 32'h0000_00FF;
                1: ra = ra & 32'h0000_FFFF;
                2: rb = 32'd0;
                3: ra = 32'd0;
                default: ;
            endcase
            do_div(rs, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
